run_status_display: RTL and testbench

RUN_STATUS_DISPLAY -- requirements
Module: run_status_display

---
 rtl/run_status_display_pkg.sv | 24 ++
 rtl/run_status_display_seg7.sv | 41 ++++
 rtl/run_status_display.sv | 163 ++++++++++++++++
 tb/tb_run_status_display.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_status_display_pkg.sv
// run_status_display_pkg -- segment glyphs, blank pattern and the slot
// one-hot helper shared by run_status_display and its seg7 decoder.
// Segment bit order everywhere is {a,b,c,d,e,f,g,dp}, active high.
package run_status_display_pkg;

    // Widest digit bank the one-hot helper can describe.
    localparam int MAX_DIG = 32;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Status glyphs shown while halted (H, L, t) and while running (r, u, n).
    localparam logic [7:0] GLYPH_H = 8'b01101110;
    localparam logic [7:0] GLYPH_L = 8'b00011100;
    localparam logic [7:0] GLYPH_T = 8'b00011110;
    localparam logic [7:0] GLYPH_R = 8'b00001010;
    localparam logic [7:0] GLYPH_U = 8'b00111000;
    localparam logic [7:0] GLYPH_N = 8'b00101010;

    // Active-high one-hot of a slot index; callers keep the low NDIG bits.
    function automatic logic [MAX_DIG-1:0] slot_onehot(input int unsigned slot);
        return MAX_DIG'(1) << slot;
    endfunction

endpackage

// File: rtl/run_status_display_seg7.sv
// seg7 -- hex nibble to seven-segment decoder, one per display bank.
// With RUN_STATUS_DISPLAY_BCD_EN defined only 0-9 decode; 10-15 blank.
module seg7
    import run_status_display_pkg::*;
(
    input  logic [3:0] num,
    input  logic       display,
    output logic [7:0] seg
);

    // Decode the nibble into segment lines, blank when display is low.
    always_comb begin
        // NOTE: seg gets a value before any branch so no path leaves it unassigned (no latch).
        seg = SEG_BLANK;
        if (display) begin
            case (num)
                4'h0: seg = 8'hFC;
                4'h1: seg = 8'h60;
                4'h2: seg = 8'hDA;
                4'h3: seg = 8'hF2;
                4'h4: seg = 8'h66;
                4'h5: seg = 8'hB6;
                4'h6: seg = 8'hBE;
                4'h7: seg = 8'hE0;
                4'h8: seg = 8'hFE;
                4'h9: seg = 8'hF6;
`ifdef RUN_STATUS_DISPLAY_BCD_EN
                default: seg = SEG_BLANK;
`else
                4'hA: seg = 8'hEE;
                4'hB: seg = 8'h3E;
                4'hC: seg = 8'h9C;
                4'hD: seg = 8'h7A;
                4'hE: seg = 8'h9E;
                4'hF: seg = 8'h8E;
`endif
            endcase
        end
    end

endmodule

// File: rtl/run_status_display.sv
// run_status_display -- free-running run counter shown on two multiplexed
// seven-segment banks: bank B shows the low counter nibbles, bank A shows
// higher nibbles plus a three-glyph run/halt status word.
// Optional build macro RUN_STATUS_DISPLAY_BCD_EN turns the counter into a
// decimal (BCD) counter; undefined gives a binary counter with hex digits.
module run_status_display
    import run_status_display_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 1024,
    parameter int CNT_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              halting,
    input  logic              clear,
    output logic [7:0]        led1,
    output logic [7:0]        led2,
    output logic [2*NDIG-1:0] led_sel
);

    localparam int SLOT_W = $clog2(NDIG);
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int NNIB   = CNT_W / 4;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NDIG - 1);
    localparam logic [SLOT_W-1:0] SLOT_G2   = SLOT_W'(NDIG - 2);
    localparam logic [SLOT_W-1:0] SLOT_G3   = SLOT_W'(NDIG - 3);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  snap;
    logic [CNT_W-1:0]  frame_src;
    logic [DIV_W-1:0]  div;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] slot_nx;
    logic              blank;
    logic              tick;
    logic              enter0;
    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [7:0]        seg_a_dig;
    logic [7:0]        seg_b_dig;
    logic [7:0]        seg_a_nx;
    logic [NDIG-1:0]   sel_oh;

`ifdef RUN_STATUS_DISPLAY_BCD_EN
    logic carry;

    // Decimal increment: each nibble rolls 9 -> 0 and carries upward.
    always_comb begin
        cnt_inc = cnt;
        carry   = 1'b1;
        for (int i = 0; i < NNIB; i++) begin
            if (carry) begin
                if (cnt[4*i +: 4] >= 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end
`else
    assign cnt_inc = cnt + CNT_W'(1);
`endif

    // Run counter: clear wins, otherwise count while not halting.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!halting) begin
            cnt <= cnt_inc;
        end
    end

    assign tick    = (div == DIV_LAST);
    // The first advance after reset lands on slot 0 so a frame always starts there.
    assign slot_nx = blank ? '0 : ((slot == SLOT_LAST) ? '0 : slot + 1'b1);
    assign enter0  = tick && (slot_nx == '0);
    // Slot 0 shows the counter being captured this edge, later slots the snapshot.
    assign frame_src = enter0 ? cnt : snap;
    assign sel_oh    = NDIG'(slot_onehot(32'(slot_nx)));

    // Scan divider: one slot period is SCAN_DIV clocks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
        end
    end

    // Frame snapshot taken as the scan enters slot 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap <= '0;
        end else if (enter0) begin
            snap <= cnt;
        end
    end

    // Pick the nibble each bank shows in the upcoming slot; out-of-range nibbles read 0.
    always_comb begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        for (int i = 0; i < NNIB; i++) begin
            if (i == int'(slot_nx)) begin
                nib_b = frame_src[4*i +: 4];
            end
            if (i == NDIG + int'(slot_nx)) begin
                nib_a = frame_src[4*i +: 4];
            end
        end
    end

    seg7 u_seg_a (
        .num     (nib_a),
        .display (1'b1),
        .seg     (seg_a_dig)
    );

    seg7 u_seg_b (
        .num     (nib_b),
        .display (1'b1),
        .seg     (seg_b_dig)
    );

    // Top three bank A slots carry the status word sampled from live halting.
    always_comb begin
        seg_a_nx = seg_a_dig;
        if (slot_nx == SLOT_LAST) begin
            seg_a_nx = halting ? GLYPH_H : GLYPH_R;
        end else if (slot_nx == SLOT_G2) begin
            seg_a_nx = halting ? GLYPH_L : GLYPH_U;
        end else if (slot_nx == SLOT_G3) begin
            seg_a_nx = halting ? GLYPH_T : GLYPH_N;
        end
    end

    // Slot, blank flag, segments and selects all move together on the slot tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot    <= '0;
            blank   <= 1'b1;
            led1    <= SEG_BLANK;
            led2    <= SEG_BLANK;
            led_sel <= '1;
        end else if (tick) begin
            slot    <= slot_nx;
            blank   <= 1'b0;
            led1    <= seg_a_nx;
            led2    <= seg_b_dig;
            led_sel <= ~{sel_oh, sel_oh};
        end
    end

endmodule

// File: tb/tb_run_status_display.sv
// tb_run_status_display -- self-checking bench for run_status_display.
// Honours RUN_STATUS_DISPLAY_BCD_EN when compiled with the RTL.
`timescale 1ns/1ps
module tb_run_status_display;

    localparam int NDIG     = 4;
    localparam int SCAN_DIV = 4;
    localparam int CNT_W    = 32;
    localparam int FRAME    = NDIG * SCAN_DIV;
    localparam logic [31:0] STATUS_HALT = 32'h6E1C1EFC;  // slot3..0: H, L, t, digit 0

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       halting = 1'b0;
    logic       clear   = 1'b0;
    logic [7:0] led1, led2, led1_8, led2_8;
    logic [2*NDIG-1:0] led_sel, led_sel_8;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] seg_tab [16];

    // Behavioural reference for the CNT_W=32 instance.
    longint unsigned m_cnt, m_snap;
    int              m_k, m_n;
    logic [7:0]      m_led1, m_led2, m_sel;

    typedef struct {
        int unsigned run;
        logic [31:0] exp_b;
        logic [31:0] exp_a;
    } vec_t;
    vec_t vecs[$];

    run_status_display #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .halting(halting), .clear(clear),
        .led1(led1), .led2(led2), .led_sel(led_sel)
    );

    run_status_display #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .CNT_W(8)) dut8 (
        .clock(clock), .reset(reset), .halting(halting), .clear(clear),
        .led1(led1_8), .led2(led2_8), .led_sel(led_sel_8)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int model_digit(input longint unsigned v, input int idx);
        longint unsigned t;
        t = v;
        if (idx >= CNT_W / 4) return 0;
`ifdef RUN_STATUS_DISPLAY_BCD_EN
        for (int i = 0; i < idx; i++) t = t / 10;
        return int'(t % 10);
`else
        return int'((t >> (4 * idx)) & 64'hF);
`endif
    endfunction

    function automatic longint unsigned model_next(input longint unsigned v);
`ifdef RUN_STATUS_DISPLAY_BCD_EN
        longint unsigned lim;
        lim = 1;
        for (int i = 0; i < CNT_W / 4; i++) lim = lim * 10;
        return (v + 1) % lim;
`else
        return (v + 1) & ((64'd1 << CNT_W) - 1);
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_snap = 0; m_k = 0; m_n = 0;
        m_led1 = 8'h00; m_led2 = 8'h00; m_sel = 8'hFF;
    endtask

    // One clock of the specification's rules: slot n after the n-th SCAN_DIV boundary.
    task automatic model_step();
        int s;
        if (reset) begin
            model_reset();
            return;
        end
        m_k++;
        if (m_k % SCAN_DIV == 0) begin
            m_n++;
            s = (m_n - 1) % NDIG;
            if (s == 0) m_snap = m_cnt;
            m_led2 = seg_tab[model_digit(m_snap, s)];
            if (s == NDIG - 1)      m_led1 = halting ? 8'b01101110 : 8'b00001010;
            else if (s == NDIG - 2) m_led1 = halting ? 8'b00011100 : 8'b00111000;
            else if (s == NDIG - 3) m_led1 = halting ? 8'b00011110 : 8'b00101010;
            else                    m_led1 = seg_tab[model_digit(m_snap, NDIG + s)];
            m_sel = 8'hFF;
            m_sel[s] = 1'b0;
            m_sel[NDIG + s] = 1'b0;
        end
        if (clear)         m_cnt = 0;
        else if (!halting) m_cnt = model_next(m_cnt);
    endtask

    // Advance to the next falling edge (one rising edge passes) and keep the model in step.
    task automatic cycle();
        @(negedge clock);
        model_step();
    endtask

    task automatic sample(input bit use8, output logic [7:0] sel, output logic [7:0] l1, output logic [7:0] l2);
        sel = use8 ? led_sel_8 : led_sel;
        l1  = use8 ? led1_8 : led1;
        l2  = use8 ? led2_8 : led2;
    endtask

    task automatic find_slot0(input bit use8, input string tag);
        logic [7:0] sel, l1, l2;
        int guard;
        guard = 0;
        sample(use8, sel, l1, l2);
        while (sel != 8'hEE && guard < 4 * FRAME) begin
            cycle();
            sample(use8, sel, l1, l2);
            guard++;
        end
        check({tag, " align"}, sel, 8'hEE);
    endtask

    // Let a fresh frame form, then read all four slots of both banks.
    task automatic capture(input bit use8, input string tag, input logic [31:0] exp_b, input logic [31:0] exp_a);
        logic [7:0] sel, l1, l2, exp_sel;
        repeat (2 * FRAME) cycle();
        find_slot0(use8, tag);
        for (int s = 0; s < NDIG; s++) begin
            sample(use8, sel, l1, l2);
            exp_sel = 8'hFF;
            exp_sel[s] = 1'b0;
            exp_sel[NDIG + s] = 1'b0;
            check($sformatf("%s slot%0d led_sel", tag, s), sel, exp_sel);
            check($sformatf("%s slot%0d led2", tag, s), l2, exp_b[8*s +: 8]);
            check($sformatf("%s slot%0d led1", tag, s), l1, exp_a[8*s +: 8]);
            repeat (SCAN_DIV) cycle();
        end
    endtask

    // Release reset with halting low; first lit slot must be slot 0 after SCAN_DIV clocks.
    task automatic release_check(input string tag);
        int k;
        reset = 1'b0;
        k = 0;
        do begin
            cycle();
            k++;
        end while (led_sel == 8'hFF && k < 3 * FRAME);
        check({tag, " latency"}, k, SCAN_DIV);
        check({tag, " led_sel"}, led_sel, 8'hEE);
        check({tag, " led2"}, led2, 8'hF2);   // snapshot holds 3 counts
        check({tag, " led1"}, led1, 8'hFC);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n8;
        logic [31:0] exp8;

        seg_tab = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
`ifdef RUN_STATUS_DISPLAY_BCD_EN
        vecs.push_back('{run: 100,  exp_b: 32'hFC60FCFC, exp_a: STATUS_HALT});
        vecs.push_back('{run: 4660, exp_b: 32'h66BEBEFC, exp_a: STATUS_HALT});
        vecs.push_back('{run: 255,  exp_b: 32'hFCDAB6B6, exp_a: STATUS_HALT});
        n8 = 99;   exp8 = 32'hFCFCF6F6;
`else
        vecs.push_back('{run: 100,  exp_b: 32'hFCFCBE66, exp_a: STATUS_HALT});
        vecs.push_back('{run: 4660, exp_b: 32'h60DAF266, exp_a: STATUS_HALT});
        vecs.push_back('{run: 2748, exp_b: 32'hFCEE3E9C, exp_a: STATUS_HALT});
        vecs.push_back('{run: 255,  exp_b: 32'hFCFC8E8E, exp_a: STATUS_HALT});
        vecs.push_back('{run: 120,  exp_b: 32'hFCFCE0FE, exp_a: STATUS_HALT});
        vecs.push_back('{run: 213,  exp_b: 32'hFCFC7AB6, exp_a: STATUS_HALT});
        vecs.push_back('{run: 158,  exp_b: 32'hFCFCF69E, exp_a: STATUS_HALT});
        n8 = 255;  exp8 = 32'hFCFC8E8E;
`endif

        // Reset takes effect before any clock edge.
        model_reset();
        #1 reset = 1'b1;
        #1;
        check("reset led1", led1, 8'h00);
        check("reset led2", led2, 8'h00);
        check("reset led_sel", led_sel, 8'hFF);
        check("reset led_sel w8", led_sel_8, 8'hFF);
        repeat (3) cycle();
        release_check("first release");

        // Reset mid-frame: blank at once, then restart at slot 0.
        repeat (FRAME + 6) cycle();
        @(posedge clock);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("midscan led1", led1, 8'h00);
        check("midscan led2", led2, 8'h00);
        check("midscan led_sel", led_sel, 8'hFF);
        cycle();
        release_check("midscan release");

        // Table: clear, run N clocks, halt, read the frozen frame.
        foreach (vecs[i]) begin
            clear = 1'b1;
            halting = 1'b0;
            cycle();
            clear = 1'b0;
            repeat (vecs[i].run) cycle();
            halting = 1'b1;
            capture(1'b0, $sformatf("run%0d", vecs[i].run), vecs[i].exp_b, vecs[i].exp_a);
        end

        // Clear while halted: counter goes to 0 and stays there.
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        capture(1'b0, "clear halted", 32'hFCFCFCFC, STATUS_HALT);

        // Toggle halting mid-frame: glyphs follow, snapshot digits do not.
        find_slot0(1'b0, "toggle");
        repeat (SCAN_DIV) cycle();
        check("toggle slot1 led1", led1, 8'b00011110);
        halting = 1'b0;
        repeat (SCAN_DIV) cycle();
        check("toggle slot2 led1", led1, 8'b00111000);
        check("toggle slot2 led2", led2, 8'hFC);
        repeat (SCAN_DIV) cycle();
        check("toggle slot3 led1", led1, 8'b00001010);
        check("toggle slot3 led2", led2, 8'hFC);

        // Running frame shows n, u, r in slots 1..3.
        find_slot0(1'b0, "running");
        repeat (SCAN_DIV) cycle();
        check("running slot1 led1", led1, 8'b00101010);
        repeat (SCAN_DIV) cycle();
        check("running slot2 led1", led1, 8'b00111000);
        repeat (SCAN_DIV) cycle();
        check("running slot3 led1", led1, 8'b00001010);

        // Narrow counter: full-scale value, then wrap to zero.
        reset = 1'b1;
        cycle();
        halting = 1'b0;
        reset = 1'b0;
        repeat (n8) cycle();
        halting = 1'b1;
        capture(1'b1, "w8 full", exp8, STATUS_HALT);
        halting = 1'b0;
        cycle();
        halting = 1'b1;
        capture(1'b1, "w8 wrap", 32'hFCFCFCFC, STATUS_HALT);

        // Random halting/clear against the reference model, with one reset pulse.
        reset = 1'b1;
        cycle();
        halting = 1'b0;
        clear = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            check($sformatf("rand%0d led1", i), led1, m_led1);
            check($sformatf("rand%0d led2", i), led2, m_led2);
            check($sformatf("rand%0d led_sel", i), led_sel, m_sel);
            if ($urandom_range(0, 7) == 0) halting = ~halting;
            clear = ($urandom_range(0, 63) == 0);
            if (i == 1500) reset = 1'b1;
            if (i == 1502) reset = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
